// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALUOp encodings and
// small helpers used by the ID/EX pipeline register.
package id_ex_reg_pkg;

  localparam int CTRL_W   = 9;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int BCNT_W   = 8;

  localparam int CTRL_REGDST_BIT   = 8;
  localparam int CTRL_REGWRITE_BIT = 7;
  localparam int CTRL_MEMREAD_BIT  = 6;
  localparam int CTRL_MEMTOREG_BIT = 5;
  localparam int CTRL_MEMWRITE_BIT = 4;
  localparam int CTRL_ALUSRC_BIT   = 3;
  localparam int CTRL_ALUOP_MSB    = 2;
  localparam int CTRL_ALUOP_LSB    = 0;

  typedef enum logic [2:0] {
    ALUOP_MEM   = 3'b000,
    ALUOP_RTYPE = 3'b010,
    ALUOP_ADDI  = 3'b011,
    ALUOP_ANDI  = 3'b100
  } alu_op_e;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  function automatic logic [REG_W-1:0] wb_dst_f(
    input logic             valid,
    input ctrl_t            ctrl,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd
  );
    if (!valid)            return '0;
    else if (ctrl.reg_dst) return rd;
    else                   return rt;
  endfunction

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic pipeline field register: synchronous reset, clear over enable.
// One cycle latency; holds its value while en is low.
module pipe_reg
  #(
    parameter int WIDTH = 32
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
  );

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset)      q_q <= '0;
    else if (clr)   q_q <= '0;
    else if (en)    q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and a saturating
// bubble counter. Priority per edge: reset > flush > stall > load.
module id_ex_reg
  import id_ex_reg_pkg::*;
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [FUNCT_W-1:0] id_funct,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_rd,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic               ex_mem_read,
    output logic [REG_W-1:0]   ex_wb_dst,
    output logic [BCNT_W-1:0]  bubble_cnt
  );

  logic              load_en;
  logic [CTRL_W-1:0] ctrl_d;
  logic              bubble_in;
  ctrl_t             ex_ctrl_s;

  assign load_en = ~stall;
  // An invalid slot must never carry side-effecting control into EX.
  assign ctrl_d  = id_valid ? id_ctrl : '0;

  pipe_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_valid), .q_o(ex_valid)
  );

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(ctrl_d), .q_o(ex_ctrl)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_rd1 (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_rd1), .q_o(ex_rd1)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_rd2 (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_rd2), .q_o(ex_rd2)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_imm (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_imm), .q_o(ex_imm)
  );

  pipe_reg #(.WIDTH(REG_W)) u_rs (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_rs), .q_o(ex_rs)
  );

  pipe_reg #(.WIDTH(REG_W)) u_rt (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_rt), .q_o(ex_rt)
  );

  pipe_reg #(.WIDTH(REG_W)) u_rd (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_rd), .q_o(ex_rd)
  );

  pipe_reg #(.WIDTH(FUNCT_W)) u_funct (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d_i(id_funct), .q_o(ex_funct)
  );

  // Hazard-facing outputs derive only from registered state.
  assign ex_ctrl_s   = ctrl_t'(ex_ctrl);
  assign ex_mem_read = ex_ctrl_s.mem_read;
  assign ex_wb_dst   = wb_dst_f(ex_valid, ex_ctrl_s, ex_rt, ex_rd);

  logic [BCNT_W-1:0] bcnt_q;
  logic [BCNT_W-1:0] bcnt_d;

  // A stalled invalid slot is a hold, not a new bubble.
  assign bubble_in = flush | (load_en & ~id_valid);

  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble_in && bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bcnt_q <= '0;
    else       bcnt_q <= bcnt_d;
  end

  assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the stage register.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [8:0]  id_ctrl;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;

  logic        ex_valid, ex_mem_read;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_wb_dst;
  logic [5:0]  ex_funct;
  logic [7:0]  bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_mem_read(ex_mem_read), .ex_wb_dst(ex_wb_dst), .bubble_cnt(bubble_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the EX stage should hold.
  bit          m_valid;
  bit [8:0]    m_ctrl;
  bit [31:0]   m_rd1, m_rd2, m_imm;
  bit [4:0]    m_rs, m_rt, m_rd;
  bit [5:0]    m_funct;
  int          m_bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    bit [4:0] exp_dst;
    exp_dst = !m_valid ? 5'd0 : (m_ctrl[8] ? m_rd : m_rt);
    chk({tag, ".valid"},    32'(ex_valid),    32'(m_valid));
    chk({tag, ".ctrl"},     32'(ex_ctrl),     32'(m_ctrl));
    chk({tag, ".rd1"},      ex_rd1,           m_rd1);
    chk({tag, ".rd2"},      ex_rd2,           m_rd2);
    chk({tag, ".imm"},      ex_imm,           m_imm);
    chk({tag, ".rs"},       32'(ex_rs),       32'(m_rs));
    chk({tag, ".rt"},       32'(ex_rt),       32'(m_rt));
    chk({tag, ".rd"},       32'(ex_rd),       32'(m_rd));
    chk({tag, ".funct"},    32'(ex_funct),    32'(m_funct));
    chk({tag, ".memread"},  32'(ex_mem_read), 32'(m_ctrl[6]));
    chk({tag, ".wbdst"},    32'(ex_wb_dst),   32'(exp_dst));
    chk({tag, ".bubbles"},  32'(bubble_cnt),  32'(m_bubbles));
  endtask

  // Advance the model by the rules for one edge, clock the DUT, compare.
  task automatic tick(input string tag);
    if (reset) begin
      m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_bubbles = 0;
    end else if (flush) begin
      m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0;
      if (m_bubbles < 255) m_bubbles++;
    end else if (!stall) begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : 9'd0;
      m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct;
      if (!id_valid && m_bubbles < 255) m_bubbles++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_id();
    id_ctrl  = 9'($urandom);
    id_rd1   = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs    = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_funct = 6'($urandom);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; id_valid = 1;
    rand_id();
    id_ctrl = 9'h1FF; id_rd1 = 32'hDEADBEEF;
    #2;
    tick("reset");
    chk("reset.cnt0", 32'(bubble_cnt), 32'd0);
    chk("reset.dst0", 32'(ex_wb_dst),  32'd0);

    // R-type load: RegDst=1, RegWrite=1, ALUOp=010
    reset = 0; rand_id();
    id_valid = 1; id_ctrl = {1'b1, 1'b1, 4'b0000, 3'b010}; id_rt = 5; id_rd = 9;
    tick("load");
    chk("load.wbdst9", 32'(ex_wb_dst), 32'd9);
    chk("load.ctrl",   32'(ex_ctrl),   32'h182);

    // lw: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=000; then stall twice
    rand_id();
    id_ctrl = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000}; id_rt = 7;
    tick("lw");
    chk("lw.memread", 32'(ex_mem_read), 32'd1);
    chk("lw.rt7",     32'(ex_rt),       32'd7);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_id(); id_valid = i[0];
      tick("stall");
    end
    chk("stall.rt7", 32'(ex_rt), 32'd7);
    chk("stall.cnt", 32'(bubble_cnt), 32'd0);

    // flush + stall with sw in decode
    flush = 1; id_valid = 1; rand_id();
    id_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000};
    tick("flush_stall");
    chk("flush_stall.cnt", 32'(bubble_cnt), 32'd1);
    stall = 0; flush = 0;

    // invalid load with all control set
    id_valid = 0; rand_id(); id_ctrl = 9'h1FF;
    tick("invalid");
    chk("invalid.ctrl", 32'(ex_ctrl),    32'd0);
    chk("invalid.cnt",  32'(bubble_cnt), 32'd2);

    // reset mid-stall with flush asserted
    reset = 1; stall = 1; flush = 1; id_valid = 1; rand_id();
    tick("reset_mid");
    reset = 0; stall = 0;

    // saturation
    for (int i = 0; i < 260; i++) begin
      rand_id();
      tick("sat");
    end
    chk("sat.255", 32'(bubble_cnt), 32'd255);
    flush = 0; id_valid = 0;
    tick("sat_hold");
    chk("sat_hold.255", 32'(bubble_cnt), 32'd255);

    reset = 1; tick("reset2"); reset = 0;

    for (int i = 0; i < 400; i++) begin
      rand_id();
      id_valid = ($urandom_range(3) != 0);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(7) == 0);
      reset    = ($urandom_range(49) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  pipeline clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold current contents (load-use hazard).
REQ-005 flush  input  1  replace incoming instruction with a bubble.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_ctrl  input  9  {RegDst, RegWrite, MemRead, MemtoReg, MemWrite, ALUSrc, ALUOp[2:0]} from the decode control unit.
REQ-008 id_rd1, id_rd2  input  32 each  register-file read data.
REQ-009 id_imm  input  32  sign-extended immediate.
REQ-010 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-011 id_funct  input  6  R-type funct field.
REQ-012 ex_valid  output  1  execute stage holds a real instruction.
REQ-013 ex_ctrl  output  9  registered control bundle, same bit order as id_ctrl.
REQ-014 ex_rd1, ex_rd2, ex_imm  output  32 each  registered data.
REQ-015 ex_rs, ex_rt, ex_rd  output  5 each; ex_funct  output  6.
REQ-016 ex_mem_read  output  1  copy of ex_ctrl MemRead bit, for hazard detection.
REQ-017 ex_wb_dst  output  5  ex_rd when RegDst=1 else ex_rt; 0 when ex_valid=0.
REQ-018 bubble_cnt  output  8  count of bubbles inserted since reset.

Function
REQ-019 Priority per edge SHALL be reset > flush > stall > load.
REQ-020 Load: all ex_* registers capture id_* values; ex_valid <= id_valid; latency exactly one cycle.
REQ-021 Load with id_valid=0: ex_ctrl SHALL be forced to all-zero (no RegWrite/MemWrite/MemRead side effects).
REQ-022 Stall (flush=0): every ex_* register and bubble_cnt SHALL hold.
REQ-023 Flush: ex_valid <= 0, ex_ctrl <= 0; data fields MAY be don't-care but SHALL be zeroed.
REQ-024 Flush and stall together: flush wins; a bubble is inserted.
REQ-025 bubble_cnt SHALL increment by 1 on every edge where a bubble enters (flush, or load with id_valid=0), saturating at 255.
REQ-026 ex_mem_read and ex_wb_dst SHALL be combinational from registered state only (no id_* to ex_* combinational path).
REQ-027 ALUOp SHALL pass unmodified; encodings 000 lw/sw, 010 R-type, 011 addi, 100 andi.

Reset
REQ-028 On reset: ex_valid=0, ex_ctrl=0, all data fields=0, bubble_cnt=0, ex_wb_dst=0.
REQ-029 Reset asserted mid-stall or with flush SHALL still produce the REQ-028 state on that edge.

Structure
REQ-030 Control-bundle width (9), bit positions, and ALUOp encodings SHALL live in the shared pipeline package.
REQ-031 One sub-module pipe_reg (parameter WIDTH; inputs en, clr) SHALL implement each field; clr has priority over en.

Verification
REQ-032 Reset: assert reset with id_ctrl=9'h1FF, id_rd1=32'hDEADBEEF -> all outputs 0 next edge.
REQ-033 Load: id_valid=1, id_ctrl={1,1,0,0,0,0,3'b010}, id_rt=5, id_rd=9 -> after one edge ex_valid=1, ex_wb_dst=9, ex_ctrl matches.
REQ-034 Stall: lw loaded (ex_mem_read=1, ex_rt=7), then stall=1 for 2 cycles with new id_* values -> outputs unchanged, bubble_cnt unchanged.
REQ-035 Flush+stall simultaneous with id_ctrl sw (MemWrite=1) -> ex_valid=0, ex_ctrl=0, bubble_cnt +1.
REQ-036 Saturation: 260 consecutive flush cycles -> bubble_cnt=255, stays 255.
REQ-037 Invalid load: id_valid=0, id_ctrl=9'h1FF -> ex_ctrl=0, ex_wb_dst=0, bubble_cnt +1.
